vlsu_axi_mem_responder: RTL

//  AXI4 subordinate memory model/responder for the VLSU master port: accepts AW/W/AR, returns B/R.

---
 rtl/riva_pkg.sv | 55 +++++
 rtl/axi_burst_addr_gen.sv | 29 ++
 rtl/vlsu_axi_mem_responder.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riva_pkg.sv
// rtl/riva_pkg.sv - shared AXI constants and channel structs for the VLSU memory responder
package riva_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam int unsigned AxiIdWidth       = 4;
    localparam int unsigned AxiDefDataWidth  = 128;
    localparam int unsigned AxiDefAddrWidth  = 32;

    typedef struct packed {
        logic [AxiIdWidth-1:0]      id;
        logic [AxiDefAddrWidth-1:0] addr;
        logic [7:0]                 len;
        logic [2:0]                 size;
        logic [1:0]                 burst;
    } axi_aw_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0]      id;
        logic [AxiDefAddrWidth-1:0] addr;
        logic [7:0]                 len;
        logic [2:0]                 size;
        logic [1:0]                 burst;
    } axi_ar_t;

    typedef struct packed {
        logic [AxiDefDataWidth-1:0]   data;
        logic [AxiDefDataWidth/8-1:0] strb;
        logic                         last;
    } axi_w_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0] id;
        logic [1:0]            resp;
    } axi_b_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0]      id;
        logic [AxiDefDataWidth-1:0] data;
        logic [1:0]                 resp;
        logic                       last;
    } axi_r_t;

    // Response encodings are ordered by severity, so the numeric max is the worst.
    function automatic logic [1:0] axi_resp_worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - per-beat address advance and burst/range error decode
module axi_burst_addr_gen
    import riva_pkg::*;
#(
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned BusBytesLog2 = 4,
    parameter int unsigned MemBytes     = 65536
) (
    input  logic [AddrWidth-1:0] addr,
    input  logic [2:0]           size,
    input  logic [1:0]           burst,
    output logic [AddrWidth-1:0] next_addr,
    output logic                 err,
    output logic                 out_of_range
);

    always_comb begin
        err = (32'(size) > BusBytesLog2) ||
              (burst == AXI_BURST_WRAP) || (burst == 2'b11);
        if (burst == AXI_BURST_FIXED) begin
            next_addr = addr;
        end else begin
            next_addr = addr + (AddrWidth'(1) << size);
        end
        // Extra bit keeps the comparison exact even if MemBytes spans the address space.
        out_of_range = {1'b0, addr} >= (AddrWidth+1)'(MemBytes);
    end

endmodule

// File: rtl/vlsu_axi_mem_responder.sv
// rtl/vlsu_axi_mem_responder.sv - AXI4 subordinate scratch memory with independent read/write engines
module vlsu_axi_mem_responder
    import riva_pkg::*;
#(
    parameter int unsigned AxiDataWidth = 128,
    parameter int unsigned AxiAddrWidth = 32,
    parameter int unsigned MemBytes     = 65536,
    parameter type axi_aw_t = riva_pkg::axi_aw_t,
    parameter type axi_ar_t = riva_pkg::axi_ar_t,
    parameter type axi_w_t  = riva_pkg::axi_w_t,
    parameter type axi_r_t  = riva_pkg::axi_r_t,
    parameter type axi_b_t  = riva_pkg::axi_b_t
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    s_axi_aw_valid_i,
    output logic    s_axi_aw_ready_o,
    input  axi_aw_t s_axi_aw_i,
    input  logic    s_axi_w_valid_i,
    output logic    s_axi_w_ready_o,
    input  axi_w_t  s_axi_w_i,
    output logic    s_axi_b_valid_o,
    input  logic    s_axi_b_ready_i,
    output axi_b_t  s_axi_b_o,
    input  logic    s_axi_ar_valid_i,
    output logic    s_axi_ar_ready_o,
    input  axi_ar_t s_axi_ar_i,
    output logic    s_axi_r_valid_o,
    input  logic    s_axi_r_ready_i,
    output axi_r_t  s_axi_r_o
);

    localparam int unsigned BusBytes = AxiDataWidth / 8;
    localparam int unsigned BusLog2  = $clog2(BusBytes);
    localparam int unsigned MemWords = MemBytes / BusBytes;
    localparam int unsigned IdxW     = $clog2(MemWords);

    typedef logic [AxiDataWidth-1:0] word_t;
    typedef logic [AxiAddrWidth-1:0] addr_t;
    typedef logic [IdxW-1:0]         idx_t;

    typedef enum logic       {R_IDLE, R_BURST}         rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP}  wr_state_e;

    function automatic word_t merge_bytes(input word_t old, input word_t data,
                                          input logic [BusBytes-1:0] strb);
        word_t res;
        res = old;
        for (int i = 0; i < BusBytes; i++) begin
            if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
        end
        return res;
    endfunction

    function automatic idx_t word_idx(input addr_t a);
        return a[BusLog2 +: IdxW];
    endfunction

    word_t mem [MemWords];

    // Holds the readies low for the first cycle after reset release.
    logic active_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) active_q <= 1'b0;
        else       active_q <= 1'b1;
    end

    rd_state_e        rd_state_q, rd_state_d;
    logic [AxiIdWidth-1:0] rd_id_q;
    addr_t            rd_addr_q;
    logic [7:0]       rd_len_q, rd_cnt_q;
    logic [2:0]       rd_size_q;
    logic [1:0]       rd_burst_q;
    logic             rd_err_q;
    word_t            r_data_q;
    logic [1:0]       r_resp_q;
    logic             r_last_q;

    addr_t            rd_gen_addr, rd_gen_next;
    logic [2:0]       rd_gen_size;
    logic [1:0]       rd_gen_burst;
    logic             rd_gen_err, rd_gen_oor;

    addr_t            load_addr;
    logic             load_err, load_oor, load_last;
    word_t            load_word, load_data;
    logic [1:0]       load_resp;
    logic             ar_hs, r_hs;

    wr_state_e        wr_state_q, wr_state_d;
    logic [AxiIdWidth-1:0] wr_id_q, b_id_q;
    addr_t            wr_addr_q, wr_gen_next;
    logic [7:0]       wr_len_q, wr_cnt_q;
    logic [2:0]       wr_size_q;
    logic [1:0]       wr_burst_q;
    logic [1:0]       wr_resp_acc_q, b_resp_q, wr_beat_resp;
    logic             wr_gen_err, wr_gen_oor;
    logic             aw_hs, w_hs, wr_commit, wr_last_beat;
    idx_t             wr_idx;

    // While idle the read generator decodes the incoming AR so the first beat loads at the handshake.
    always_comb begin
        if (rd_state_q == R_IDLE) begin
            rd_gen_addr  = s_axi_ar_i.addr;
            rd_gen_size  = s_axi_ar_i.size;
            rd_gen_burst = s_axi_ar_i.burst;
        end else begin
            rd_gen_addr  = rd_addr_q;
            rd_gen_size  = rd_size_q;
            rd_gen_burst = rd_burst_q;
        end
    end

    axi_burst_addr_gen #(
        .AddrWidth   (AxiAddrWidth),
        .BusBytesLog2(BusLog2),
        .MemBytes    (MemBytes)
    ) u_rd_addr_gen (
        .addr        (rd_gen_addr),
        .size        (rd_gen_size),
        .burst       (rd_gen_burst),
        .next_addr   (rd_gen_next),
        .err         (rd_gen_err),
        .out_of_range(rd_gen_oor)
    );

    always_comb begin
        rd_state_d       = rd_state_q;
        s_axi_ar_ready_o = 1'b0;
        s_axi_r_valid_o  = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                s_axi_ar_ready_o = active_q;
                if (s_axi_ar_valid_i && active_q) rd_state_d = R_BURST;
            end
            R_BURST: begin
                s_axi_r_valid_o = 1'b1;
                if (s_axi_r_ready_i && r_last_q) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    assign ar_hs = s_axi_ar_valid_i && s_axi_ar_ready_o;
    assign r_hs  = s_axi_r_valid_o && s_axi_r_ready_i;

    // Next R payload; a write committing to the same word this cycle is forwarded so the
    // beat presented next sees the new bytes while the beat handshaking now keeps the old ones.
    always_comb begin
        if (rd_state_q == R_IDLE) begin
            load_addr = s_axi_ar_i.addr;
            load_err  = rd_gen_err;
            load_oor  = rd_gen_oor;
            load_last = (s_axi_ar_i.len == 8'd0);
        end else begin
            load_addr = rd_gen_next;
            load_err  = rd_err_q;
            load_oor  = {1'b0, rd_gen_next} >= (AxiAddrWidth+1)'(MemBytes);
            load_last = ((rd_cnt_q + 8'd1) == rd_len_q);
        end
        load_word = mem[word_idx(load_addr)];
        if (wr_commit && (wr_idx == word_idx(load_addr))) begin
            load_word = merge_bytes(load_word, s_axi_w_i.data, s_axi_w_i.strb);
        end
        load_data = (load_err || load_oor) ? '0 : load_word;
        load_resp = load_err ? AXI_RESP_SLVERR :
                    load_oor ? AXI_RESP_DECERR : AXI_RESP_OKAY;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rd_state_q <= R_IDLE;
        else       rd_state_q <= rd_state_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_id_q    <= '0;
            rd_addr_q  <= '0;
            rd_len_q   <= '0;
            rd_cnt_q   <= '0;
            rd_size_q  <= '0;
            rd_burst_q <= '0;
            rd_err_q   <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= AXI_RESP_OKAY;
            r_last_q   <= 1'b0;
        end else if (ar_hs) begin
            rd_id_q    <= s_axi_ar_i.id;
            rd_addr_q  <= s_axi_ar_i.addr;
            rd_len_q   <= s_axi_ar_i.len;
            rd_cnt_q   <= '0;
            rd_size_q  <= s_axi_ar_i.size;
            rd_burst_q <= s_axi_ar_i.burst;
            rd_err_q   <= rd_gen_err;
            r_data_q   <= load_data;
            r_resp_q   <= load_resp;
            r_last_q   <= load_last;
        end else if (r_hs && !r_last_q) begin
            rd_addr_q  <= rd_gen_next;
            rd_cnt_q   <= rd_cnt_q + 8'd1;
            r_data_q   <= load_data;
            r_resp_q   <= load_resp;
            r_last_q   <= load_last;
        end
    end

    always_comb begin
        s_axi_r_o      = '0;
        s_axi_r_o.id   = rd_id_q;
        s_axi_r_o.data = r_data_q;
        s_axi_r_o.resp = r_resp_q;
        s_axi_r_o.last = r_last_q;
    end

    axi_burst_addr_gen #(
        .AddrWidth   (AxiAddrWidth),
        .BusBytesLog2(BusLog2),
        .MemBytes    (MemBytes)
    ) u_wr_addr_gen (
        .addr        (wr_addr_q),
        .size        (wr_size_q),
        .burst       (wr_burst_q),
        .next_addr   (wr_gen_next),
        .err         (wr_gen_err),
        .out_of_range(wr_gen_oor)
    );

    assign wr_last_beat = (wr_cnt_q == wr_len_q);

    always_comb begin
        wr_state_d       = wr_state_q;
        s_axi_aw_ready_o = 1'b0;
        s_axi_w_ready_o  = 1'b0;
        s_axi_b_valid_o  = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                s_axi_aw_ready_o = active_q;
                if (s_axi_aw_valid_i && active_q) wr_state_d = W_DATA;
            end
            W_DATA: begin
                s_axi_w_ready_o = 1'b1;
                if (s_axi_w_valid_i && wr_last_beat) wr_state_d = W_RESP;
            end
            W_RESP: begin
                s_axi_b_valid_o = 1'b1;
                if (s_axi_b_ready_i) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    assign aw_hs     = s_axi_aw_valid_i && s_axi_aw_ready_o;
    assign w_hs      = s_axi_w_valid_i && s_axi_w_ready_o;
    assign wr_commit = w_hs && !wr_gen_err && !wr_gen_oor;
    assign wr_idx    = word_idx(wr_addr_q);

    // Beat count, not w.last, ends the burst; a disagreeing last only degrades the response.
    always_comb begin
        if (wr_gen_err)      wr_beat_resp = AXI_RESP_SLVERR;
        else if (wr_gen_oor) wr_beat_resp = AXI_RESP_DECERR;
        else                 wr_beat_resp = AXI_RESP_OKAY;
        if (s_axi_w_i.last != wr_last_beat) begin
            wr_beat_resp = axi_resp_worst(wr_beat_resp, AXI_RESP_SLVERR);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) wr_state_q <= W_IDLE;
        else       wr_state_q <= wr_state_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_id_q       <= '0;
            wr_addr_q     <= '0;
            wr_len_q      <= '0;
            wr_cnt_q      <= '0;
            wr_size_q     <= '0;
            wr_burst_q    <= '0;
            wr_resp_acc_q <= AXI_RESP_OKAY;
            b_id_q        <= '0;
            b_resp_q      <= AXI_RESP_OKAY;
        end else if (aw_hs) begin
            wr_id_q       <= s_axi_aw_i.id;
            wr_addr_q     <= s_axi_aw_i.addr;
            wr_len_q      <= s_axi_aw_i.len;
            wr_cnt_q      <= '0;
            wr_size_q     <= s_axi_aw_i.size;
            wr_burst_q    <= s_axi_aw_i.burst;
            wr_resp_acc_q <= AXI_RESP_OKAY;
        end else if (w_hs) begin
            wr_addr_q     <= wr_gen_next;
            wr_cnt_q      <= wr_cnt_q + 8'd1;
            wr_resp_acc_q <= axi_resp_worst(wr_resp_acc_q, wr_beat_resp);
            if (wr_last_beat) begin
                b_id_q   <= wr_id_q;
                b_resp_q <= axi_resp_worst(wr_resp_acc_q, wr_beat_resp);
            end
        end
    end

    always_comb begin
        s_axi_b_o      = '0;
        s_axi_b_o.id   = b_id_q;
        s_axi_b_o.resp = b_resp_q;
    end

    // Backing store is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (wr_commit) begin
            mem[wr_idx] <= merge_bytes(mem[wr_idx], s_axi_w_i.data, s_axi_w_i.strb);
        end
    end

endmodule
